// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU; results return through a 2-entry response FIFO.
// Latency 1 cycle, 1 op/cycle; requests stall only when the FIFO is full and its head is not being drained.

module alu_arbiter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign rd_vld = (count != '0);
  assign pop    = rd_vld && rd_rdy;
  // A pop while full frees a slot in the same cycle.
  assign wr_rdy = (count < CW'(DEPTH)) || pop;
  assign push   = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr];

  // Pointers wrap by overflow, so DEPTH must be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

module alu_arbiter #(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_WIDTH = 32,
  parameter  int TAG_WIDTH  = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b_i,
  input  logic [NUM_REQ*5-1:0]          req_alu_op_i,
  input  logic [NUM_REQ-1:0]            req_invert_i,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_i,
  output logic [DATA_WIDTH-1:0]         alu_operands_a_o,
  output logic [DATA_WIDTH-1:0]         alu_operands_b_o,
  output logic [4:0]                    alu_op_o,
  output logic                          alu_invert_o,
  input  logic [DATA_WIDTH-1:0]         alu_result_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [TAG_WIDTH-1:0]          rsp_tag_o,
  output logic [DATA_WIDTH-1:0]         rsp_result_o
);
  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] result;
  } rsp_t;

  logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] op_b [NUM_REQ];
  logic [4:0]            op   [NUM_REQ];
  logic [TAG_WIDTH-1:0]  tag  [NUM_REQ];

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cand;
  logic            cand_vld;
  logic            can_accept;
  logic            hs;
  logic            push_vld;
  int              idx;
  rsp_t            push_dat;
  rsp_t            head;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign op_a[g] = req_op_a_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign op_b[g] = req_op_b_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign op[g]   = req_alu_op_i[g*5 +: 5];
    assign tag[g]  = req_tag_i[g*TAG_WIDTH +: TAG_WIDTH];

    // A pending request must hold all its fields until it is granted.
    a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[g] && !req_ready_o[g]) |=>
        (req_valid_i[g] && $stable(op_a[g]) && $stable(op_b[g]) && $stable(op[g]) &&
         $stable(req_invert_i[g]) && $stable(tag[g])));
  end

  a_one_grant : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!cand_vld && req_valid_i[idx[ID_W-1:0]]) begin
        cand_vld = 1'b1;
        cand     = idx[ID_W-1:0];
      end
    end
  end

  // ALU inputs follow the candidate even while stalled so they stay stable.
  always_comb begin
    alu_operands_a_o = '0;
    alu_operands_b_o = '0;
    alu_op_o         = '0;
    alu_invert_o     = 1'b0;
    if (cand_vld) begin
      alu_operands_a_o = op_a[cand];
      alu_operands_b_o = op_b[cand];
      alu_op_o         = op[cand];
      alu_invert_o     = req_invert_i[cand];
    end
  end

  assign push_vld = cand_vld && !rst_i;
  assign hs       = push_vld && can_accept;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[cand] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  assign push_dat.id     = cand;
  assign push_dat.tag    = tag[cand];
  assign push_dat.result = alu_result_i;

  alu_arbiter_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (2)
  ) u_rsp_fifo (
    .clk    (clk_i),
    .rst    (rst_i),
    .wr_vld (push_vld),
    .wr_rdy (can_accept),
    .wr_dat (push_dat),
    .rd_vld (rsp_valid_o),
    .rd_rdy (rsp_ready_i),
    .rd_dat (head)
  );

  assign rsp_id_o     = head.id;
  assign rsp_tag_o    = head.tag;
  assign rsp_result_o = head.result;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: hand vectors for the corner cases, then random traffic against a queue model.
module tb_alu_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int IW = 1;

  localparam logic [4:0] OP_ADD_SUB = 5'd0;
  localparam logic [4:0] OP_AND     = 5'd1;
  localparam logic [4:0] OP_OR      = 5'd2;
  localparam logic [4:0] OP_XOR     = 5'd3;
  localparam logic [4:0] OP_SHIFT   = 5'd4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  logic          rvld [N];
  logic [DW-1:0] ra   [N];
  logic [DW-1:0] rb   [N];
  logic [4:0]    rop  [N];
  logic          rinv [N];
  logic [TW-1:0] rtag [N];

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] op_a_flat;
  logic [N*DW-1:0] op_b_flat;
  logic [N*5-1:0]  op_flat;
  logic [N-1:0]    inv_flat;
  logic [N*TW-1:0] tag_flat;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [4:0]      alu_op;
  logic            alu_inv;
  logic [DW-1:0]   alu_res;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [DW-1:0]   rsp_result;

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [4:0] op, input logic inv);
    logic signed [DW-1:0] sa;
    sa = a;
    case (op)
      OP_ADD_SUB: return inv ? a - b : a + b;
      OP_AND:     return a & b;
      OP_OR:      return a | b;
      OP_XOR:     return a ^ b;
      OP_SHIFT: begin
        if (inv) return sa >>> b[4:0];
        return a << b[4:0];
      end
      default:    return '0;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  always_comb alu_res = alu_fn(alu_a, alu_b, alu_op, alu_inv);

  always_comb begin
    req_valid = '0;
    op_a_flat = '0;
    op_b_flat = '0;
    op_flat   = '0;
    inv_flat  = '0;
    tag_flat  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = rvld[i];
      op_a_flat[i*DW +: DW] = ra[i];
      op_b_flat[i*DW +: DW] = rb[i];
      op_flat[i*5 +: 5]     = rop[i];
      inv_flat[i]           = rinv[i];
      tag_flat[i*TW +: TW]  = rtag[i];
    end
  end

  alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_a_i       (op_a_flat),
    .req_op_b_i       (op_b_flat),
    .req_alu_op_i     (op_flat),
    .req_invert_i     (inv_flat),
    .req_tag_i        (tag_flat),
    .alu_operands_a_o (alu_a),
    .alu_operands_b_o (alu_b),
    .alu_op_o         (alu_op),
    .alu_invert_o     (alu_inv),
    .alu_result_i     (alu_res),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_id_o         (rsp_id),
    .rsp_tag_o        (rsp_tag),
    .rsp_result_o     (rsp_result)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            id;
    logic [TW-1:0] tag;
    logic [DW-1:0] res;
  } exp_t;

  typedef struct {
    logic [N-1:0] vld;
    logic         rdy;
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    int           exp_id;
  } vec_t;

  exp_t         q[$];
  int           mrr;
  logic [N-1:0] seen_ready;
  vec_t         tv[$];

  function automatic vec_t mk(input logic [N-1:0] vld, input logic rdy, input logic [N-1:0] er,
                              input logic ev, input int eid);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.exp_ready = er; v.exp_valid = ev; v.exp_id = eid;
    return v;
  endfunction

  // One clock of the reference model: pick the round-robin winner among valid requesters,
  // compare all outputs, then update the FIFO queue and pointer at the edge.
  task automatic cycle();
    int           c;
    bit           found;
    bit           can;
    logic [N-1:0] er;
    exp_t         e;
    @(negedge clk_i);
    found = 0;
    c     = 0;
    for (int k = 0; k < N; k++)
      if (!found && rvld[(mrr + k) % N]) begin
        found = 1;
        c     = (mrr + k) % N;
      end
    can = (q.size() < 2) || (rsp_ready && q.size() == 2);
    er  = '0;
    if (found && can) er[c] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("alu_a", alu_a, found ? ra[c] : '0);
    chk("alu_b", alu_b, found ? rb[c] : '0);
    chk("alu_op", alu_op, found ? rop[c] : 5'd0);
    chk("alu_inv", alu_inv, found ? rinv[c] : 1'b0);
    chk("rsp_valid", rsp_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_tag", rsp_tag, q[0].tag);
      chk("rsp_result", rsp_result, q[0].res);
    end
    seen_ready = req_ready;
    @(posedge clk_i);
    if (q.size() != 0 && rsp_ready) q.delete(0);
    if (found && can) begin
      e.id  = c;
      e.tag = rtag[c];
      e.res = alu_fn(ra[c], rb[c], rop[c], rinv[c]);
      q.push_back(e);
      mrr = (c + 1) % N;
    end
    #1;
  endtask

  // Pending requests hold; granted or idle requesters may start a new one.
  task automatic drive_reqs(input int new_pct);
    for (int i = 0; i < N; i++)
      if (!(rvld[i] && !seen_ready[i])) begin
        rvld[i] = ($urandom_range(0, 99) < new_pct);
        ra[i]   = $urandom;
        rb[i]   = $urandom;
        rop[i]  = 5'($urandom_range(0, 5));
        rinv[i] = 1'($urandom_range(0, 1));
        rtag[i] = TW'($urandom);
      end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rvld[i] = 0; ra[i] = '0; rb[i] = '0; rop[i] = '0; rinv[i] = 0; rtag[i] = '0;
    end
    rsp_ready  = 0;
    seen_ready = '0;

    // Reset state, with requests presented while reset is held.
    repeat (2) @(posedge clk_i);
    #1;
    ra[0] = 32'd12; rb[0] = 32'd10; rop[0] = OP_AND; rtag[0] = 4'h3;
    ra[1] = 32'd7;  rb[1] = 32'd1;  rop[1] = OP_XOR; rtag[1] = 4'h9;
    rvld[0] = 1; rvld[1] = 1;
    #1;
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_tag", rsp_tag, 0);
    chk("reset_rsp_result", rsp_result, 0);
    rvld[0] = 0; rvld[1] = 0;
    @(posedge clk_i);
    #1 rst_i = 0;

    // Contention, backpressure, full with simultaneous pop and push, drain.
    tv.push_back(mk(2'b00, 1, 2'b00, 0, 0));
    tv.push_back(mk(2'b10, 1, 2'b10, 0, 0));
    tv.push_back(mk(2'b11, 1, 2'b01, 1, 1));
    tv.push_back(mk(2'b11, 1, 2'b10, 1, 0));
    tv.push_back(mk(2'b11, 1, 2'b01, 1, 1));
    tv.push_back(mk(2'b11, 0, 2'b10, 1, 0));
    tv.push_back(mk(2'b11, 0, 2'b00, 1, 0));
    tv.push_back(mk(2'b11, 1, 2'b01, 1, 0));
    tv.push_back(mk(2'b10, 0, 2'b00, 1, 1));
    tv.push_back(mk(2'b10, 1, 2'b10, 1, 1));
    tv.push_back(mk(2'b00, 1, 2'b00, 1, 0));
    tv.push_back(mk(2'b00, 1, 2'b00, 1, 1));
    tv.push_back(mk(2'b00, 1, 2'b00, 0, 0));
    foreach (tv[r]) begin
      for (int i = 0; i < N; i++) rvld[i] = tv[r].vld[i];
      rsp_ready = tv[r].rdy;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_ready", r), req_ready, tv[r].exp_ready);
      chk($sformatf("tbl%0d_rsp_valid", r), rsp_valid, tv[r].exp_valid);
      if (tv[r].exp_valid) chk($sformatf("tbl%0d_rsp_id", r), rsp_id, tv[r].exp_id);
      @(posedge clk_i);
      #1;
    end

    // Single request: 5 - 3 from requester 1.
    ra[1] = 32'd5; rb[1] = 32'd3; rop[1] = OP_ADD_SUB; rinv[1] = 1; rtag[1] = 4'h9;
    rvld[1] = 1;
    rsp_ready = 1;
    @(negedge clk_i);
    chk("single_ready", req_ready, 2'b10);
    chk("single_alu_a", alu_a, 5);
    chk("single_alu_b", alu_b, 3);
    chk("single_alu_op", alu_op, OP_ADD_SUB);
    chk("single_alu_inv", alu_inv, 1);
    @(posedge clk_i);
    #1 rvld[1] = 0;
    @(negedge clk_i);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 1);
    chk("single_rsp_tag", rsp_tag, 4'h9);
    chk("single_rsp_result", rsp_result, 2);
    @(posedge clk_i);
    #1;

    // Clean restart so the model begins from a known state.
    rst_i = 1;
    #2 rst_i = 0;
    q.delete();
    mrr = 0;
    seen_ready = '0;
    for (int i = 0; i < N; i++) rvld[i] = 0;

    // Idle: ALU inputs zero, no responses, pointer must hold.
    rsp_ready = 1;
    repeat (10) cycle();

    // Fill to two entries with no drain, then reset asynchronously mid-cycle.
    rsp_ready = 0;
    drive_reqs(100);
    cycle();
    drive_reqs(100);
    cycle();
    drive_reqs(100);
    cycle();
    #2 rst_i = 1;
    #1;
    chk("rst_async_rsp_valid", rsp_valid, 0);
    chk("rst_async_req_ready", req_ready, 2'b00);
    @(posedge clk_i);
    #1 rst_i = 0;
    q.delete();
    mrr = 0;
    #1;
    chk("rst_first_grant", req_ready, 2'b01);
    rsp_ready = 1;

    // Random traffic with phases of heavy backpressure.
    for (int n = 0; n < 3000; n++) begin
      if ((n / 200) % 3 == 2) rsp_ready = ($urandom_range(0, 99) < 20);
      else                    rsp_ready = ($urandom_range(0, 99) < 75);
      cycle();
      drive_reqs(60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
